// File: rtl/id_exe_pipe_reg.sv
// Elastic ID/EXE pipeline register: valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module id_exe_pipe_reg #(
  parameter int unsigned WORD_LEN          = 16,
  parameter int unsigned REG_FILE_ADDR_LEN = 3,
  parameter int unsigned EXE_CMD_LEN       = 4,
  parameter int unsigned INSTR_LEN         = 16,
  parameter int unsigned SKID              = 1,
  parameter int unsigned CNT_W             = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic [3:0]                   ctrl_in,
  input  logic [EXE_CMD_LEN-1:0]       exe_cmd_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2_in,
  input  logic [WORD_LEN-1:0]          st_value_in,
  input  logic [WORD_LEN-1:0]          val1_in,
  input  logic [WORD_LEN-1:0]          val2_in,
  input  logic [WORD_LEN-1:0]          pc_in,
  input  logic [INSTR_LEN-1:0]         instr_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   ctrl_out,
  output logic [EXE_CMD_LEN-1:0]       exe_cmd_out,
  output logic [REG_FILE_ADDR_LEN-1:0] dest_out,
  output logic [REG_FILE_ADDR_LEN-1:0] src1_out,
  output logic [REG_FILE_ADDR_LEN-1:0] src2_out,
  output logic [WORD_LEN-1:0]          st_value_out,
  output logic [WORD_LEN-1:0]          val1_out,
  output logic [WORD_LEN-1:0]          val2_out,
  output logic [WORD_LEN-1:0]          pc_out,
  output logic [INSTR_LEN-1:0]         instr_out,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned SlotW = 4 + EXE_CMD_LEN + 3 * REG_FILE_ADDR_LEN + 4 * WORD_LEN +
                                  INSTR_LEN;

  logic [SlotW-1:0] in_slot;
  logic [SlotW-1:0] main_q, main_d;
  logic [SlotW-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [3:0]       ctrl_raw;
  logic             accept;
  logic             issue;

  assign in_slot = {ctrl_in, exe_cmd_in, dest_in, src1_in, src2_in,
                    st_value_in, val1_in, val2_in, pc_in, instr_in};

  assign {ctrl_raw, exe_cmd_out, dest_out, src1_out, src2_out,
          st_value_out, val1_out, val2_out, pc_out, instr_out} = main_q;

  // A bubble must never carry live control enables into EXE.
  assign ctrl_out  = ctrl_raw & {4{main_v_q}};
  assign out_valid = main_v_q;
  assign stall_cnt = stall_q;

  assign in_ready = (SKID != 0) ? !skid_v_q : (!main_v_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = main_v_q && out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (SKID != 0) begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (accept) begin
            main_v_d = 1'b1;
            main_d   = in_slot;
          end
        end
        2'b10: begin
          if (accept && issue) begin
            main_d = in_slot;
          end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = in_slot;
          end else if (issue) begin
            main_v_d = 1'b0;
          end
        end
        2'b11: begin
          if (issue) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; drop the stray flag.
          skid_v_d = 1'b0;
        end
      endcase
    end else begin
      if (accept) begin
        main_v_d = 1'b1;
        main_d   = in_slot;
      end else if (issue) begin
        main_v_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_v_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: a SKID=1/CNT_W=8 and a SKID=0/CNT_W=4 instance share
// stimulus; each has its own scoreboard queue and stall-count model.
module tb_id_exe_pipe_reg;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [15:0] pc;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [3:0]  ctrl_in;
  logic [15:0] pc_in;
  logic [3:0]  exe_cmd_in;
  logic [2:0]  dest_in, src1_in, src2_in;
  logic [15:0] st_value_in, val1_in, val2_in, instr_in;

  logic        o1_rdy, o1_v, o0_rdy, o0_v;
  logic [3:0]  o1_ctrl, o1_exe, o0_ctrl, o0_exe;
  logic [2:0]  o1_dest, o1_s1, o1_s2, o0_dest, o0_s1, o0_s2;
  logic [15:0] o1_st, o1_v1, o1_v2, o1_pc, o1_ins;
  logic [15:0] o0_st, o0_v1, o0_v2, o0_pc, o0_ins;
  logic [7:0]  o1_stall;
  logic [3:0]  o0_stall;

  slot_t q1[$];
  slot_t q0[$];
  int    stall1 = 0;
  int    stall0 = 0;
  int    checks = 0;
  int    failures = 0;

  function automatic logic [3:0] f_exe(input logic [15:0] p);
    return p[3:0] ^ 4'h5;
  endfunction
  function automatic logic [2:0] f_dest(input logic [15:0] p);
    return p[2:0];
  endfunction
  function automatic logic [2:0] f_src1(input logic [15:0] p);
    return p[5:3];
  endfunction
  function automatic logic [2:0] f_src2(input logic [15:0] p);
    return ~p[2:0];
  endfunction
  function automatic logic [15:0] f_st(input logic [15:0] p);
    return p + 16'h1000;
  endfunction
  function automatic logic [15:0] f_v1(input logic [15:0] p);
    return p ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] f_v2(input logic [15:0] p);
    return ~p;
  endfunction
  function automatic logic [15:0] f_ins(input logic [15:0] p);
    return {p[7:0], p[15:8]};
  endfunction

  assign exe_cmd_in  = f_exe(pc_in);
  assign dest_in     = f_dest(pc_in);
  assign src1_in     = f_src1(pc_in);
  assign src2_in     = f_src2(pc_in);
  assign st_value_in = f_st(pc_in);
  assign val1_in     = f_v1(pc_in);
  assign val2_in     = f_v2(pc_in);
  assign instr_in    = f_ins(pc_in);

  always #5 clk = ~clk;

  id_exe_pipe_reg #(.SKID(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_rdy), .flush(flush),
    .ctrl_in(ctrl_in), .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .st_value_in(st_value_in), .val1_in(val1_in), .val2_in(val2_in),
    .pc_in(pc_in), .instr_in(instr_in), .out_valid(o1_v), .out_ready(out_ready),
    .ctrl_out(o1_ctrl), .exe_cmd_out(o1_exe), .dest_out(o1_dest), .src1_out(o1_s1),
    .src2_out(o1_s2), .st_value_out(o1_st), .val1_out(o1_v1), .val2_out(o1_v2),
    .pc_out(o1_pc), .instr_out(o1_ins), .stall_cnt(o1_stall)
  );

  id_exe_pipe_reg #(.SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_rdy), .flush(flush),
    .ctrl_in(ctrl_in), .exe_cmd_in(exe_cmd_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .st_value_in(st_value_in), .val1_in(val1_in), .val2_in(val2_in),
    .pc_in(pc_in), .instr_in(instr_in), .out_valid(o0_v), .out_ready(out_ready),
    .ctrl_out(o0_ctrl), .exe_cmd_out(o0_exe), .dest_out(o0_dest), .src1_out(o0_s1),
    .src2_out(o0_s2), .st_value_out(o0_st), .val1_out(o0_v1), .val2_out(o0_v2),
    .pc_out(o0_pc), .instr_out(o0_ins), .stall_cnt(o0_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input string t, input logic ov, input logic ir,
                           input logic [3:0] ct, input logic [3:0] ex,
                           input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [15:0] st, input logic [15:0] v1, input logic [15:0] v2,
                           input logic [15:0] pc, input logic [15:0] ins, input int stl,
                           input bit ev, input slot_t e, input bit er, input int es);
    chk({t, ".out_valid"}, 32'(ov), 32'(ev));
    chk({t, ".in_ready"}, 32'(ir), 32'(er));
    chk({t, ".stall_cnt"}, stl, es);
    if (ev) begin
      chk({t, ".pc_out"}, 32'(pc), 32'(e.pc));
      chk({t, ".ctrl_out"}, 32'(ct), 32'(e.ctrl));
      chk({t, ".exe_cmd_out"}, 32'(ex), 32'(f_exe(e.pc)));
      chk({t, ".dest_out"}, 32'(d), 32'(f_dest(e.pc)));
      chk({t, ".src1_out"}, 32'(s1), 32'(f_src1(e.pc)));
      chk({t, ".src2_out"}, 32'(s2), 32'(f_src2(e.pc)));
      chk({t, ".st_value_out"}, 32'(st), 32'(f_st(e.pc)));
      chk({t, ".val1_out"}, 32'(v1), 32'(f_v1(e.pc)));
      chk({t, ".val2_out"}, 32'(v2), 32'(f_v2(e.pc)));
      chk({t, ".instr_out"}, 32'(ins), 32'(f_ins(e.pc)));
    end else begin
      chk({t, ".bubble_ctrl"}, 32'(ct), 32'h0);
    end
  endtask

  task automatic check_zero(input string t, input logic ov, input logic ir,
                            input logic [3:0] ct, input logic [3:0] ex,
                            input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                            input logic [15:0] st, input logic [15:0] v1, input logic [15:0] v2,
                            input logic [15:0] pc, input logic [15:0] ins, input int stl);
    chk({t, ".rst_out_valid"}, 32'(ov), 32'h0);
    chk({t, ".rst_in_ready"}, 32'(ir), 32'h1);
    chk({t, ".rst_stall_cnt"}, stl, 32'h0);
    chk({t, ".rst_fields"}, 32'({ct, ex, d, s1, s2}), 32'h0);
    chk({t, ".rst_words"}, 32'(st | v1 | v2 | pc | ins), 32'h0);
  endtask

  // Entered one time unit after a rising edge; checks at the falling edge.
  task automatic step(input logic v, input logic [15:0] pc, input logic [3:0] ct,
                      input logic ordy, input logic fl);
    bit    er1, er0;
    slot_t h1, h0;
    in_valid  = v;
    pc_in     = pc;
    ctrl_in   = ct;
    out_ready = ordy;
    flush     = fl;
    #4;
    er1 = (q1.size() < 2);
    er0 = (q0.size() == 0) || ordy;
    h1  = '0;
    h0  = '0;
    if (q1.size() != 0) h1 = q1[0];
    if (q0.size() != 0) h0 = q0[0];
    check_one("skid1", o1_v, o1_rdy, o1_ctrl, o1_exe, o1_dest, o1_s1, o1_s2, o1_st, o1_v1,
              o1_v2, o1_pc, o1_ins, int'(o1_stall), q1.size() != 0, h1, er1, stall1);
    check_one("skid0", o0_v, o0_rdy, o0_ctrl, o0_exe, o0_dest, o0_s1, o0_s2, o0_st, o0_v1,
              o0_v2, o0_pc, o0_ins, int'(o0_stall), q0.size() != 0, h0, er0, stall0);
    if (q1.size() != 0 && !ordy && stall1 < 255) stall1++;
    if (q0.size() != 0 && !ordy && stall0 < 15) stall0++;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() != 0 && ordy) void'(q1.pop_front());
      if (q0.size() != 0 && ordy) void'(q0.pop_front());
      if (v && er1) q1.push_back('{ctrl: ct, pc: pc});
      if (v && er0) q0.push_back('{ctrl: ct, pc: pc});
    end
    @(posedge clk);
    #1;
  endtask

  // Reset held with live traffic and flush asserted: reset must win.
  task automatic do_reset(input int n);
    rst       = 1'b0;
    in_valid  = 1'b1;
    pc_in     = 16'hFFFF;
    ctrl_in   = 4'hF;
    out_ready = 1'b0;
    flush     = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    q1.delete();
    q0.delete();
    stall1 = 0;
    stall0 = 0;
    #4;
    check_zero("skid1", o1_v, o1_rdy, o1_ctrl, o1_exe, o1_dest, o1_s1, o1_s2, o1_st, o1_v1,
               o1_v2, o1_pc, o1_ins, int'(o1_stall));
    check_zero("skid0", o0_v, o0_rdy, o0_ctrl, o0_exe, o0_dest, o0_s1, o0_s2, o0_st, o0_v1,
               o0_v2, o0_pc, o0_ins, int'(o0_stall));
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ctrl_in = 4'h0; pc_in = 16'h0;
    #1;
    do_reset(2);

    // Full-rate stream
    step(1'b1, 16'h0010, 4'b0001, 1'b1, 1'b0);
    step(1'b1, 16'h0011, 4'b0010, 1'b1, 1'b0);
    step(1'b1, 16'h0012, 4'b0100, 1'b1, 1'b0);
    step(1'b1, 16'h0013, 4'b1000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);

    // Backpressure and release
    step(1'b1, 16'h0020, 4'b0011, 1'b1, 1'b0);
    step(1'b1, 16'h0021, 4'b0101, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 4'b0110, 1'b1, 1'b0);
    step(1'b1, 16'h0022, 4'b0110, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);

    // Flush from FULL with a slot offered in the flush cycle
    step(1'b1, 16'h0030, 4'b1010, 1'b0, 1'b0);
    step(1'b1, 16'h0031, 4'b1010, 1'b0, 1'b0);
    step(1'b1, 16'h0032, 4'b1010, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    // Flush while an accept would otherwise happen
    step(1'b1, 16'h0040, 4'b0110, 1'b0, 1'b0);
    step(1'b1, 16'h0041, 4'b0111, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 16'h0042, 4'b1001, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);

    // Long stall: the 4-bit counter saturates at 15
    step(1'b1, 16'h0050, 4'b1100, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    do_reset(1);

    // FULL with five stall cycles, then reset mid-operation
    step(1'b1, 16'h0060, 4'b1010, 1'b0, 1'b0);
    step(1'b1, 16'h0061, 4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0);
    chk("skid1.stall_before_reset", 32'(o1_stall), 32'd5);
    do_reset(1);

    step(1'b1, 16'h0070, 4'b0011, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'b0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
